ifft_1d_8_seq: RTL and testbench
================================

// Module: ifft_1d_8_seq
// PURPOSE
// Sequential 8-point radix-2 DIF inverse FFT. It is the receive-side counterpart of the
// combinational fft_1d_8 datapath. Complex samples stream in one per cycle over a
// valid/ready handshake into an 8-entry buffer. One shared butterfly with a conjugate-twiddle
// multiplier runs 12 operations (3 stages x 4). Results stream out in natural order, scaled by 1/8.
// PARAMETERS
// DW  16  sample width per real/imag component, two's complement
// TW  16  twiddle width, Q2.14 (1.0 = 16384)
// PORTS
// clk        in   1   clock, rising edge
// reset_     in   1   asynchronous active-low reset
// in_valid   in   1   input sample valid
// in_ready   out  1   block accepts an input sample
// in_r       in   DW  input sample, real
// in_i       in   DW  input sample, imaginary
// out_valid  out  1   output sample valid
// out_ready  in   1   downstream accepts an output sample
// out_r      out  DW  output sample, real
// out_i      out  DW  output sample, imaginary
// out_last   out  1   high with sample index 7 of the frame
// BEHAVIOUR
// - Reset (async, reset_=0): state LOAD, all counters 0, buffer 0. Outputs: in_ready=1
//   once reset is released; out_valid=0, out_last=0, out_r=0, out_i=0.
// - FSM LOAD -> CALC -> OUT -> LOAD. There is no IDLE state; LOAD waits for input.
// - LOAD: in_ready=1. A transfer occurs when in_valid&&in_ready. The sample is written to
//   buf[wcnt] in natural order and wcnt increments. The 8th transfer (wcnt=7) moves to CALC.
// - CALC: in_ready=0, out_valid=0. One butterfly per cycle for 12 cycles.
//   - Stage s=0,1,2 has span h=4>>s. Pair p=0..3 uses indices a,b=a+h, where a = (p/h)*2h + p%h.
//   - Butterfly: A'=(A+B)>>>1 and B'=((A-B)>>>1)*W, with W=e^{+j*2*pi*(p%h)*2^s/8}.
//   - Twiddle ROM: k0=(16384,0), k1=(11585,11585), k2=(0,16384), k3=(-11585,11585).
//   - Complex multiply: re=dr*wr-di*wi and im=dr*wi+di*wr, full precision, then >>>14
//     (truncation toward -inf), then saturate to DW bits.
//   - Add/sub uses DW+1 bits before the >>>1 and cannot overflow.
//   - At the end of the 12th cycle, move to OUT.
// - OUT: in_ready=0. out_r/out_i = buf[bitrev3(rcnt)], registered, so X[n] emerges in order
//   n=0..7. out_last = (rcnt==7).
//   - On out_valid&&out_ready, rcnt increments.
//   - Without out_ready, the presented sample holds stable.
//   - After the transfer with out_last, the FSM enters LOAD and in_ready=1 on the next cycle.
// - Latency: first out_valid appears 13 cycles after the clock edge that accepts input 7.
//   Back-to-back frame period is 8 + 12 + 8 cycles, plus any stall cycles.
// - in_valid during CALC/OUT is ignored (no transfer). Input data is sampled only when a
//   transfer occurs.
// - Reset asserted mid-frame (any state) aborts the frame immediately and returns to reset
//   values. Partial data is discarded and never output.
// TESTING
// 1. Impulse: x0=(8192,0), x1..x7=0 -> X0..X7 all (1024,0), exact.
// 2. DC: x0..x7=(8000,0) -> X0=(8000,0), X1..X7=(0,0), +/-1 LSB.
// 3. x1=(8192,0), others 0 -> X0=(1024,0), X1=(724,724), X2=(0,1024), X3=(-724,724),
//    X4=(-1024,0), X5=(-724,-724), X6=(0,-1024), X7=(724,-724); tolerance +/-2 LSB.
// 4. Backpressure: out_ready pattern 1,0,0,1,0,1... -> out_r/out_i stable while stalled,
//    order X0..X7 kept, out_last only with X7; in_ready=0 throughout CALC/OUT.
// 5. Round trip: random frame through fft_1d_8_top, then scale per its gain, then this block
//    -> original samples recovered within +/-4 LSB.
// 6. reset_ pulsed low during CALC cycle 6 -> out_valid=0 immediately.
//    The next full frame (test 1 vectors) gives the correct result with no leftover samples.

Source files
------------

// File: rtl/ifft_1d_8_seq.sv
// ---------------------------------------------------------------------------
// ifft_1d_8_seq
//
// Sequential 8-point radix-2 decimation-in-frequency inverse FFT.
// Samples arrive one per cycle in natural order and are stored in an 8-entry
// buffer. A single shared butterfly then runs 12 operations (3 stages x 4
// pairs), one per cycle, in place. Each stage halves both butterfly outputs,
// so the frame comes out scaled by 1/8. Results are read back through a
// 3-bit bit reversal, so X[0..7] leave in natural order.
//
// Ports
//   clk        rising-edge clock
//   reset_     asynchronous active-low reset
//   in_valid   input sample valid
//   in_ready   block accepts an input sample (LOAD state only)
//   in_r/in_i  input sample, real / imaginary, DW-bit two's complement
//   out_valid  output sample valid
//   out_ready  downstream accepts the output sample
//   out_r/out_i output sample, real / imaginary, DW-bit two's complement
//   out_last   high together with X[7] of the frame
//
// Handshake: on both ports a transfer happens on a rising clock edge where
// valid and ready are both high. A presented output sample (out_valid=1)
// holds its data and out_last stable until it is transferred; in_ready does
// not depend on in_valid, and input data is sampled only on a transfer.
//
// The FSM state is kept in the internal signal 'state' (LOAD/CALC/OUT) so
// checkers can bind to it directly.
// ---------------------------------------------------------------------------
module ifft_1d_8_seq #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_r,
  input  logic [DW-1:0] in_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_r,
  output logic [DW-1:0] out_i,
  output logic          out_last
);

  // Twiddles are Q2.14: 1.0 = 2^(TW-2)
  localparam int FRAC = TW - 2;
  localparam int PW   = DW + TW;     // one partial product
  localparam int SW   = PW + 1;      // sum/difference of two partial products
  localparam int SHW  = SW - FRAC;   // after the >>> FRAC rescale

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam logic signed [TW-1:0] W_ONE = TW'(16384);
  localparam logic signed [TW-1:0] W_C45 = TW'(11585);
  localparam logic signed [TW-1:0] W_ZRO = TW'(0);
  localparam logic signed [TW-1:0] W_NC45 = TW'(-11585);

  logic [1:0] state;
  logic [2:0] wcnt;            // write pointer while loading
  logic [3:0] ccnt;            // butterfly counter 0..11
  logic [2:0] rcnt;            // output sample index

  logic signed [DW-1:0] mem_r [8];
  logic signed [DW-1:0] mem_i [8];

  // -------------------------------------------------------------------------
  // Butterfly addressing: stage s = ccnt[3:2], pair p = ccnt[1:0].
  // Span h = 4>>s, a = (p/h)*2h + p%h, b = a + h, twiddle k = (p%h)*2^s.
  // -------------------------------------------------------------------------
  logic [1:0] stage;
  logic [1:0] pair;
  logic [2:0] idx_a;
  logic [2:0] idx_b;
  logic [1:0] tw_k;

  always_comb begin
    stage = ccnt[3:2];
    pair  = ccnt[1:0];
    idx_a = '0;
    idx_b = '0;
    tw_k  = '0;
    case (stage)
      2'd0: begin                        // h = 4
        idx_a = {1'b0, pair};
        idx_b = {1'b1, pair};
        tw_k  = pair;
      end
      2'd1: begin                        // h = 2
        idx_a = {pair[1], 1'b0, pair[0]};
        idx_b = {pair[1], 1'b1, pair[0]};
        tw_k  = {pair[0], 1'b0};
      end
      default: begin                     // h = 1, twiddle always 1
        idx_a = {pair, 1'b0};
        idx_b = {pair, 1'b1};
        tw_k  = 2'd0;
      end
    endcase
  end

  // Conjugate-direction twiddle ROM: W = e^{+j*2*pi*k/8}
  logic signed [TW-1:0] w_r;
  logic signed [TW-1:0] w_i;

  always_comb begin
    w_r = W_ONE;
    w_i = W_ZRO;
    case (tw_k)
      2'd0: begin w_r = W_ONE;  w_i = W_ZRO; end
      2'd1: begin w_r = W_C45;  w_i = W_C45; end
      2'd2: begin w_r = W_ZRO;  w_i = W_ONE; end
      default: begin w_r = W_NC45; w_i = W_C45; end
    endcase
  end

  // -------------------------------------------------------------------------
  // Butterfly datapath
  // -------------------------------------------------------------------------
  logic signed [DW-1:0] a_r, a_i, b_r, b_i;
  logic signed [DW:0]   sum_r, sum_i, dif_r, dif_i;
  logic signed [DW-1:0] hs_r, hs_i, hd_r, hd_i;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SW-1:0] m_re, m_im;
  logic signed [SHW-1:0] sh_re, sh_im;
  logic signed [DW-1:0] mul_r, mul_i;

  // Clamp a rescaled product back into DW bits
  function automatic logic [DW-1:0] sat(input logic signed [SHW-1:0] v);
    logic [SHW-DW:0] top;
    top = v[SHW-1:DW-1];
    if (top == '0 || top == '1) sat = v[DW-1:0];
    else if (v[SHW-1])          sat = {1'b1, {(DW-1){1'b0}}};
    else                        sat = {1'b0, {(DW-1){1'b1}}};
  endfunction

  always_comb begin
    a_r = mem_r[idx_a];
    a_i = mem_i[idx_a];
    b_r = mem_r[idx_b];
    b_i = mem_i[idx_b];

    // One guard bit keeps the add/sub exact before halving
    sum_r = {a_r[DW-1], a_r} + {b_r[DW-1], b_r};
    sum_i = {a_i[DW-1], a_i} + {b_i[DW-1], b_i};
    dif_r = {a_r[DW-1], a_r} - {b_r[DW-1], b_r};
    dif_i = {a_i[DW-1], a_i} - {b_i[DW-1], b_i};

    hs_r = DW'(sum_r >>> 1);
    hs_i = DW'(sum_i >>> 1);
    hd_r = DW'(dif_r >>> 1);
    hd_i = DW'(dif_i >>> 1);

    p_rr = $signed({{TW{hd_r[DW-1]}}, hd_r}) * $signed({{DW{w_r[TW-1]}}, w_r});
    p_ii = $signed({{TW{hd_i[DW-1]}}, hd_i}) * $signed({{DW{w_i[TW-1]}}, w_i});
    p_ri = $signed({{TW{hd_r[DW-1]}}, hd_r}) * $signed({{DW{w_i[TW-1]}}, w_i});
    p_ir = $signed({{TW{hd_i[DW-1]}}, hd_i}) * $signed({{DW{w_r[TW-1]}}, w_r});

    m_re = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
    m_im = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};

    // Arithmetic shift = truncation toward -inf
    sh_re = SHW'(m_re >>> FRAC);
    sh_im = SHW'(m_im >>> FRAC);

    mul_r = sat(sh_re);
    mul_i = sat(sh_im);
  end

  // Next output index, bit-reversed into the buffer
  logic [2:0] rnext;
  logic [2:0] rd_idx;

  always_comb begin
    rnext  = rcnt + 3'd1;
    rd_idx = {rnext[0], rnext[1], rnext[2]};
  end

  // in_ready stays low while reset is held
  assign in_ready = (state == LOAD) && reset_;

  // -------------------------------------------------------------------------
  // Control and storage
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state     <= LOAD;
      wcnt      <= '0;
      ccnt      <= '0;
      rcnt      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      for (int k = 0; k < 8; k++) begin
        mem_r[k] <= '0;
        mem_i[k] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            mem_r[wcnt] <= in_r;
            mem_i[wcnt] <= in_i;
            wcnt        <= wcnt + 3'd1;
            if (wcnt == 3'd7) begin
              state <= CALC;
              ccnt  <= '0;
            end
          end
        end

        CALC: begin
          mem_r[idx_a] <= hs_r;
          mem_i[idx_a] <= hs_i;
          mem_r[idx_b] <= mul_r;
          mem_i[idx_b] <= mul_i;
          if (ccnt == 4'd11) begin
            // The last butterfly only touches entries 6 and 7, so entry 0
            // (X[0]) is already final and can be presented right away.
            ccnt      <= '0;
            state     <= OUT;
            rcnt      <= '0;
            out_r     <= mem_r[0];
            out_i     <= mem_i[0];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end else begin
            ccnt <= ccnt + 4'd1;
          end
        end

        OUT: begin
          if (out_ready) begin
            if (rcnt == 3'd7) begin
              state     <= LOAD;
              rcnt      <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              rcnt     <= rnext;
              out_r    <= mem_r[rd_idx];
              out_i    <= mem_i[rd_idx];
              out_last <= (rcnt == 3'd6);
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft_1d_8_seq.sv
// ---------------------------------------------------------------------------
// tb_ifft_1d_8_seq
//
// Bench for ifft_1d_8_seq. Directed frames are checked against known
// transform values, random frames against an integer DIF model, and
// round-trip frames against the original samples after a real-valued DFT.
// ---------------------------------------------------------------------------
module tb_ifft_1d_8_seq;

  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_r;
  logic [DW-1:0] in_i;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_r;
  logic [DW-1:0] out_i;
  logic          out_last;

  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  ifft_1d_8_seq #(.DW(DW), .TW(16)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_i      (in_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_last  (out_last)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [2*DW-1:0] exp_q[$];   // {real, imag} expected per output sample

  int fr_r[8];                 // frame to drive
  int fr_i[8];
  int unsigned first_acc;      // cycle of first accepted sample of last frame

  int tw_r[4] = '{16384, 11585, 0, -11585};
  int tw_i[4] = '{0, 11585, 16384, 11585};
  int pat[6]  = '{1, 0, 0, 1, 0, 1};

  task automatic check_val(input string tag, input int got, input int exp, input int tol);
    n_tests++;
    if (got - exp > tol || exp - got > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", tag, got, exp, tol, cyc_cnt);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int bitrev3(input int n);
    return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
  endfunction

  task automatic push_exp(input int r, input int i);
    exp_q.push_back({16'(r), 16'(i)});
  endtask

  // In-place DIF inverse transform on plain integers
  task automatic model_push();
    int ar[8];
    int ai[8];
    for (int n = 0; n < 8; n++) begin ar[n] = fr_r[n]; ai[n] = fr_i[n]; end
    for (int s = 0; s < 3; s++) begin
      int h;
      h = 4 >> s;
      for (int p = 0; p < 4; p++) begin
        int a, b, k, dr, di, nr, ni;
        a  = (p / h) * 2 * h + p % h;
        b  = a + h;
        k  = (p % h) * (1 << s);
        dr = (ar[a] - ar[b]) >>> 1;
        di = (ai[a] - ai[b]) >>> 1;
        nr = (ar[a] + ar[b]) >>> 1;
        ni = (ai[a] + ai[b]) >>> 1;
        ar[a] = nr;
        ai[a] = ni;
        ar[b] = sat16((dr * tw_r[k] - di * tw_i[k]) >>> 14);
        ai[b] = sat16((dr * tw_i[k] + di * tw_r[k]) >>> 14);
      end
    end
    for (int n = 0; n < 8; n++) push_exp(ar[bitrev3(n)], ai[bitrev3(n)]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    reset_    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_r      = '0;
    in_i      = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", int'(out_valid), 0, 0);
    check_val("rst_out_last",  int'(out_last), 0, 0);
    check_val("rst_out_r",     int'($signed(out_r)), 0, 0);
    check_val("rst_out_i",     int'($signed(out_i)), 0, 0);
    reset_ = 1'b1;
    #1;
    check_val("rst_in_ready", int'(in_ready), 1, 0);
    @(posedge clk);
    #1;
  endtask

  // Drive up to 'count' samples of fr_r/fr_i; dense = in_valid held high
  task automatic send_frame(input bit dense, input int count);
    int  i;
    int  guard;
    bit  fire;
    i = 0;
    guard = 0;
    while (i < count && guard < 200) begin
      in_valid = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (in_valid) begin
        in_r = 16'(fr_r[i]);
        in_i = 16'(fr_i[i]);
      end else begin
        in_r = 16'($urandom);
        in_i = 16'($urandom);
      end
      fire = in_valid && in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (fire) begin
        if (i == 0) first_acc = cyc_cnt;
        i++;
      end
    end
    check_val("frame_sent", i, count, 0);
    in_valid = 1'b0;
  endtask

  // Collect one frame. mode 0: always ready, 1: fixed stall pattern, 2: random
  task automatic collect(input int mode, input int tol);
    int          cyc;
    int          got;
    bit          seen;
    bit          stalled;
    logic [31:0] held;
    logic [31:0] e;
    cyc = 0;
    got = 0;
    seen = 1'b0;
    stalled = 1'b0;
    held = '0;
    while (got < 8 && cyc < 300) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[cyc % 6][0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      // junk on the input port must be ignored while busy
      in_valid = 1'($urandom_range(0, 1));
      in_r     = 16'($urandom);
      in_i     = 16'($urandom);
      check_val("in_ready_busy", int'(in_ready), 0, 0);
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          // 13th cycle after the edge that took sample 7
          check_val("latency", cyc, 12, 0);
        end
        if (stalled) begin
          check_val("hold_r", int'($signed(out_r)), int'($signed(held[31:16])), 0);
          check_val("hold_i", int'($signed(out_i)), int'($signed(held[15:0])), 0);
        end
        e = exp_q.size() > 0 ? exp_q[0] : '0;
        check_val("out_r", int'($signed(out_r)), int'($signed(e[31:16])), tol);
        check_val("out_i", int'($signed(out_i)), int'($signed(e[15:0])), tol);
        check_val("out_last", int'(out_last), (got == 7) ? 1 : 0, 0);
        if (out_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = {out_r, out_i};
        end
      end else if (seen) begin
        check_val("valid_gap", int'(out_valid), 1, 0);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_val("frame_done", got, 8, 0);
    check_val("valid_after", int'(out_valid), 0, 0);
    check_val("ready_after", int'(in_ready), 1, 0);
    exp_q.delete();
  endtask

  task automatic clear_frame();
    for (int n = 0; n < 8; n++) begin fr_r[n] = 0; fr_i[n] = 0; end
  endtask

  task automatic random_frame(input bit full);
    logic [15:0] t;
    for (int n = 0; n < 8; n++) begin
      t = 16'($urandom);
      fr_r[n] = full ? int'($signed(t)) : $urandom_range(0, 4000) - 2000;
      t = 16'($urandom);
      fr_i[n] = full ? int'($signed(t)) : $urandom_range(0, 4000) - 2000;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int unsigned acc_a;
    int xr[8];
    int xi[8];

    apply_reset();

    // Impulse: every output (1024, 0) exactly
    clear_frame();
    fr_r[0] = 8192;
    send_frame(1'b1, 8);
    acc_a = first_acc;
    for (int n = 0; n < 8; n++) push_exp(1024, 0);
    collect(0, 0);

    // DC, started back to back: frame period 28 cycles
    for (int n = 0; n < 8; n++) begin fr_r[n] = 8000; fr_i[n] = 0; end
    send_frame(1'b1, 8);
    check_val("frame_period", int'(first_acc - acc_a), 28, 0);
    push_exp(8000, 0);
    for (int n = 1; n < 8; n++) push_exp(0, 0);
    collect(0, 1);

    // Single tone at x1, with the stall pattern on out_ready
    clear_frame();
    fr_r[1] = 8192;
    send_frame(1'b0, 8);
    push_exp(1024, 0);   push_exp(724, 724);
    push_exp(0, 1024);   push_exp(-724, 724);
    push_exp(-1024, 0);  push_exp(-724, -724);
    push_exp(0, -1024);  push_exp(724, -724);
    collect(1, 2);

    // Random frames against the integer model (full range hits saturation)
    for (int f = 0; f < 6; f++) begin
      random_frame(f[0]);
      send_frame(f[1], 8);
      model_push();
      collect(f % 3, 0);
    end

    // Round trip: forward DFT in real arithmetic, then back through the DUT
    for (int f = 0; f < 3; f++) begin
      random_frame(1'b0);
      for (int n = 0; n < 8; n++) begin xr[n] = fr_r[n]; xi[n] = fr_i[n]; end
      for (int k = 0; k < 8; k++) begin
        real sr, si, ang;
        sr = 0.0;
        si = 0.0;
        for (int n = 0; n < 8; n++) begin
          ang = -2.0 * 3.14159265358979 * real'(k * n) / 8.0;
          sr = sr + real'(xr[n]) * $cos(ang) - real'(xi[n]) * $sin(ang);
          si = si + real'(xr[n]) * $sin(ang) + real'(xi[n]) * $cos(ang);
        end
        fr_r[k] = $rtoi(sr + ((sr >= 0.0) ? 0.5 : -0.5));
        fr_i[k] = $rtoi(si + ((si >= 0.0) ? 0.5 : -0.5));
      end
      send_frame(1'b0, 8);
      for (int n = 0; n < 8; n++) push_exp(xr[n], xi[n]);
      collect(2, 4);
    end

    // Reset during CALC cycle 6 aborts the frame
    random_frame(1'b1);
    send_frame(1'b1, 8);
    repeat (5) @(posedge clk);
    #1;
    reset_ = 1'b0;
    #1;
    check_val("abort_out_valid", int'(out_valid), 0, 0);
    check_val("abort_in_ready", int'(in_ready), 0, 0);
    check_val("abort_out_r", int'($signed(out_r)), 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_ = 1'b1;
    @(posedge clk);
    #1;
    check_val("abort_idle", int'(out_valid), 0, 0);
    clear_frame();
    fr_r[0] = 8192;
    send_frame(1'b1, 8);
    for (int n = 0; n < 8; n++) push_exp(1024, 0);
    collect(2, 0);

    // Reset mid-load discards the partial frame
    random_frame(1'b1);
    send_frame(1'b1, 3);
    #1;
    reset_ = 1'b0;
    #1;
    check_val("load_abort_ready", int'(in_ready), 0, 0);
    @(posedge clk);
    #1;
    reset_ = 1'b1;
    @(posedge clk);
    #1;
    clear_frame();
    fr_r[0] = 8192;
    send_frame(1'b0, 8);
    for (int n = 0; n < 8; n++) push_exp(1024, 0);
    collect(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
